// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div datapath.
//   DEFAULT_WIDTH : operand width shared by the multiplier and the divider
//   DEFAULT_CNT_W : iteration counter width used by the divider
//   state_t       : divider FSM encoding (IDLE/CALC/FIX/DONE)
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/response bundle for the sequential divider.
//
// Handshake semantics (both directions): a transfer happens on a rising
// clock edge where valid and ready are both high. A source holds valid and
// its payload stable until that edge; a sink may raise or lower ready freely.
//
//   request  : in_valid, in_ready, in_signed, dividend, divisor
//   response : out_valid, out_ready, quotient, remainder, div_by_zero
//
// Modports:
//   master : the requester/consumer (drives the request, accepts the response)
//   slave  : the divider
interface seq_divider_32_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/twos_negate.sv
// Conditional two's-complement negator.
//   in     : WIDTH-bit value
//   neg_en : 1 = output -in, 0 = output in unchanged
//   out    : result (wraps, so -(2^(WIDTH-1)) maps to itself)
module twos_negate
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg_en,
    output logic [WIDTH-1:0] out
);

    assign out = neg_en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/seq_divider_32.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of seq_divider_32_if (request and response ports)
//   dbg_state  : current FSM state, for observation only
//
// Signed mode works on magnitudes and fixes the signs afterwards: the
// quotient truncates toward zero and the remainder takes the dividend's sign.
// A zero divisor short-circuits straight to DONE with quotient = all ones and
// remainder = dividend. Parameters: WIDTH >= 2, 2**CNT_W > WIDTH.
module seq_divider_32
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_divider_32_if.slave   bus,
    output logic [1:0]        dbg_state
);

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;       // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] b_reg;       // divisor magnitude
    logic [WIDTH:0]   p_reg;       // partial remainder
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             accept;
    logic             divisor_zero;
    logic             last_iter;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quotient_fix;
    logic [WIDTH-1:0] remainder_fix;
    logic [WIDTH+1:0] trial;
    logic             trial_ge;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] a_next;

    assign accept       = bus.in_valid & (state == IDLE);
    assign divisor_zero = (bus.divisor == '0);
    assign last_iter    = (cnt == CNT_W'(WIDTH - 1));

    // Operand conditioning: magnitudes of the signed operands.
    twos_negate #(.WIDTH(WIDTH)) u_neg_dividend (
        .in     (bus.dividend),
        .neg_en (bus.in_signed & bus.dividend[WIDTH-1]),
        .out    (dividend_mag)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_divisor (
        .in     (bus.divisor),
        .neg_en (bus.in_signed & bus.divisor[WIDTH-1]),
        .out    (divisor_mag)
    );

    // Result fix-up: restore the signs of quotient and remainder.
    twos_negate #(.WIDTH(WIDTH)) u_neg_quotient (
        .in     (a_reg),
        .neg_en (q_neg),
        .out    (quotient_fix)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_remainder (
        .in     (p_reg[WIDTH-1:0]),
        .neg_en (r_neg),
        .out    (remainder_fix)
    );

    // One restoring step. {P, A} shifted left is formed inline; the extra top
    // bit of the trial difference is the borrow, so trial_ge means T >= 0.
    always_comb begin
        trial    = {p_reg, a_reg[WIDTH-1]} - {2'b00, b_reg};
        trial_ge = ~trial[WIDTH+1];
        p_next   = trial_ge ? trial[WIDTH:0] : {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
        a_next   = {a_reg[WIDTH-2:0], trial_ge};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            p_reg       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            a_reg <= dividend_mag;
                            b_reg <= divisor_mag;
                            p_reg <= '0;
                            cnt   <= '0;
                            q_neg <= bus.in_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            r_neg <= bus.in_signed & bus.dividend[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    p_reg <= p_next;
                    a_reg <= a_next;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient_r  <= quotient_fix;
                    remainder_r <= remainder_fix;
                    dbz_r       <= 1'b0;
                end
                default: begin
                    // DONE: results held until and after the handshake.
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_seq_divider_32.sv
module tb_seq_divider_32;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries are {div_by_zero, quotient, remainder}.
    logic [2*W:0] exp_q[$];

    seq_divider_32_if #(.WIDTH(W)) ifc ();

    seq_divider_32 #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with 64-bit intermediates, which
    // truncates toward zero and wraps -2^31/-1 naturally when cut to 32 bits.
    function automatic logic [2*W:0] model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) begin
            return {1'b1, {W{1'b1}}, a};
        end
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, q[W-1:0], r[W-1:0]};
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 want 0");
            end else begin
                check("sb_result", 96'({ifc.div_by_zero, ifc.quotient, ifc.remainder}), 96'(exp_q[0]));
                check("sb_in_ready_low", 96'(ifc.in_ready), 96'(0));
                if (ifc.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input string name, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int elat, input int hold);
        logic [2*W:0] m;
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        int n;
        int lat;
        m = model(sg, a, b);
        check($sformatf("%s_model", name), 96'(m), 96'({ez, eq, er}));
        exp_q.push_back(m);

        n = 0;
        while (!ifc.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_ready_wait", name), 96'(n < 100), 96'(1));

        ifc.in_valid  = 1'b1;
        ifc.in_signed = sg;
        ifc.dividend  = a;
        ifc.divisor   = b;
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        ifc.in_signed = 1'($urandom_range(0, 1));
        ifc.dividend  = $urandom;
        ifc.divisor   = $urandom;

        // lat counts edges with the accept edge as edge 1.
        lat = 1;
        while (!ifc.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s_latency", name), 96'(lat), 96'(elat));
        check($sformatf("%s_quotient", name), 96'(ifc.quotient), 96'(eq));
        check($sformatf("%s_remainder", name), 96'(ifc.remainder), 96'(er));
        check($sformatf("%s_dbz", name), 96'(ifc.div_by_zero), 96'(ez));
        q0 = ifc.quotient;
        r0 = ifc.remainder;

        if (hold > 0) begin
            // Backpressure with a stray request that must be ignored.
            for (int i = 0; i < hold; i++) begin
                ifc.in_valid = 1'b1;
                ifc.dividend = $urandom;
                ifc.divisor  = $urandom;
                @(posedge clk); #1;
            end
            ifc.in_valid = 1'b0;
            check($sformatf("%s_hold_valid", name), 96'(ifc.out_valid), 96'(1));
            check($sformatf("%s_hold_q", name), 96'({ifc.quotient, ifc.remainder}), 96'({q0, r0}));
            check($sformatf("%s_hold_state", name), 96'(dbg_state), 96'(DONE));
        end

        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        check($sformatf("%s_valid_drop", name), 96'(ifc.out_valid), 96'(0));
        check($sformatf("%s_idle_ready", name), 96'(ifc.in_ready), 96'(1));
        check($sformatf("%s_kept", name), 96'({ifc.quotient, ifc.remainder}), 96'({q0, r0}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_signed = 1'b0;
        ifc.dividend  = '0;
        ifc.divisor   = '0;
        ifc.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 96'(ifc.in_ready), 96'(1));
        check("reset_out_valid", 96'(ifc.out_valid), 96'(0));
        check("reset_outputs", 96'({ifc.div_by_zero, ifc.quotient, ifc.remainder}), 96'(0));
        check("reset_state", 96'(dbg_state), 96'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u_39483_321", 1'b0, 32'd39483, 32'd321, 32'd123, 32'd0, 1'b0, 34, 0);
        run_op("u_ffffffff_ffff", 1'b0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00010001, 32'h0, 1'b0, 34, 0);
        run_op("u_256_7", 1'b0, 32'h00000100, 32'h00000007, 32'd36, 32'd4, 1'b0, 34, 0);
        run_op("s_m654_123", 1'b1, 32'hFFFFFD72, 32'd123, 32'hFFFFFFFB, 32'hFFFFFFD9, 1'b0, 34, 0);
        run_op("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 34, 0);
        run_op("dbz", 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, 0);
        run_op("u_100_7_after_dbz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);
        run_op("s_7_m2_backpressure", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34, 10);
        run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);
        run_op("u_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 0);
        run_op("u_msb_vs_signed", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 34, 0);

        // Reset in the middle of an iteration run.
        ifc.in_valid  = 1'b1;
        ifc.in_signed = 1'b0;
        ifc.dividend  = 32'd1000000;
        ifc.divisor   = 32'd3;
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("midcalc_state", 96'(dbg_state), 96'(CALC));
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_in_ready", 96'(ifc.in_ready), 96'(1));
        check("midcalc_rst_out_valid", 96'(ifc.out_valid), 96'(0));
        check("midcalc_rst_outputs", 96'({ifc.div_by_zero, ifc.quotient, ifc.remainder}), 96'(0));
        check("midcalc_rst_state", 96'(dbg_state), 96'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midcalc_no_result", 96'(ifc.out_valid), 96'(0));
        run_op("u_100_7_after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
- Iterative radix-2 restoring divider: the inverse operation to the team's 32-bit Wallace multiplier in the mult/div datapath.
- Takes a 32-bit dividend and a 32-bit divisor through a valid/ready request port.
- Computes the quotient and remainder one bit per clock.
- Returns the result through a valid/ready response port.
- Supports unsigned mode and two's-complement signed mode, selected per request.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits. Must be ≥ 2.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_signed  in  1  1 = signed two's-complement operation, 0 = unsigned.
- dividend  in  WIDTH  numerator, sampled on the accept edge.
- divisor  in  WIDTH  denominator, sampled on the accept edge.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- quotient  out  WIDTH  result quotient; registered.
- remainder  out  WIDTH  result remainder; registered.
- div_by_zero  out  1  set with the result when divisor == 0.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - Reset mid-operation abandons the calculation; no result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge is in_valid & in_ready.
  - If divisor == 0:
    - Go to DONE.
    - quotient = all ones, remainder = dividend unchanged, div_by_zero=1.
  - Otherwise:
    - Latch the magnitudes. In signed mode, negate a negative operand; in unsigned mode, use the raw value.
    - Latch q_neg = in_signed & (sign(dividend) ^ sign(divisor)).
    - Latch r_neg = in_signed & sign(dividend).
    - Clear the partial remainder P (WIDTH+1 bits) and set counter=0. Go to CALC.
- CALC (one iteration per edge):
  - Shift {P, A} left by 1.
  - Compute T = P − {0, B}.
  - If T ≥ 0: P = T and set A[0]=1. Else restore P and A[0]=0.
  - counter++. After the WIDTH-th iteration (counter == WIDTH−1 on entry), go to FIX.
- FIX:
  - quotient = q_neg ? −A : A.
  - remainder = r_neg ? −P[WIDTH−1:0] : P[WIDTH−1:0].
  - div_by_zero=0. Go to DONE.
- DONE:
  - out_valid=1. Outputs are held stable while out_valid & !out_ready (backpressure can last indefinitely).
  - On out_valid & out_ready, go to IDLE; out_valid drops next cycle.
  - Outputs keep their last value after the handshake.
- Latency:
  - Normal: out_valid rises WIDTH+2 edges after the accept edge (1 load + WIDTH iterations + 1 fix). For WIDTH=32 this is 34 edges.
  - Divide by zero: out_valid rises 1 edge after accept.
- Throughput: one operation in flight. in_ready=0 in CALC, FIX and DONE, so a new request is not accepted in the same cycle as the result handshake. The minimum gap is one IDLE cycle.
- Signed boundary: −2^(W−1) / −1 gives quotient = 0x80000000, remainder = 0 (natural wrap, no flag).
- Sign rule: remainder takes the sign of the dividend; quotient truncates toward zero (C semantics).
- in_signed, dividend and divisor are don't-care outside the accept edge.

Decomposition:
- Shared package `multdiv_pkg`:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - Default WIDTH=32, shared with the multiplier.
- One natural sub-module, `twos_negate`: WIDTH-wide conditional negator (in, neg_en → out). It is instantiated for operand conditioning and result fix-up.
- The subtract/restore step stays inline.

Test Plan:
- Unsigned 39483 / 321 (in_signed=0) → quotient=123, remainder=0, div_by_zero=0. out_valid rises exactly 34 edges after accept.
- Unsigned 0xFFFFFFFF / 0x0000FFFF → quotient=0x00010001, remainder=0. Then 0x00000100 / 0x00000007 → quotient=36, remainder=4.
- Signed −654 (0xFFFFFD72) / 123 → quotient=−5 (0xFFFFFFFB), remainder=−39 (0xFFFFFFD9). Then signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: 0x12345678 / 0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. out_valid rises 1 edge after accept. The next normal request clears div_by_zero.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required:
  - Outputs stay stable.
  - in_ready=0 throughout, and an in_valid pulse is ignored.
  - After out_ready=1, the block returns to IDLE and accepts the next request.
- Reset mid-CALC: pulse rst_n low at iteration 15. Required:
  - All outputs return to reset values asynchronously.
  - No out_valid appears.
  - A following 100 / 7 request yields quotient=14, remainder=2.
